// File: rtl/mem_stage.sv
// mem_stage: consumer of the EX/MEM buffer. Runs the data-memory req/ack
// access, stalls upstream while it is outstanding, registers MEM/WB, and
// exposes branch resolution and a forwarding tap from the incoming word.
module mem_stage #(
  parameter int unsigned N       = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2*N+17:0]  exMemIn,
  input  logic             inValid,
  output logic             memReq,
  output logic             memWe,
  output logic [N-1:0]     memAddr,
  output logic [N-1:0]     memWData,
  input  logic [N-1:0]     memRData,
  input  logic             memAck,
  output logic             stall,
  output logic             memErr,
  output logic             branchTaken,
  output logic [N-1:0]     branchTarget,
  output logic             fwdRegWrite,
  output logic [3:0]       fwdRc,
  output logic [N-1:0]     fwdValue,
  output logic             wbValid,
  output logic             wbRegWrite,
  output logic             wbMemToReg,
  output logic [N-1:0]     wbAluResult,
  output logic [N-1:0]     wbReadData,
  output logic [3:0]       wbRc
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef struct packed {
    logic [N-1:0] alu;
    logic         zero;
    logic         neg;
    logic         br;
    logic         mw;
    logic         m2r;
    logic         rw;
    logic [3:0]   ra;
    logic [3:0]   rb;
    logic [3:0]   rc;
    logic [N-1:0] rd3;
  } ex_mem_t;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  ex_mem_t       w_in;
  logic          w_access;
  logic          w_unused;
  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic          w_latch, w_err_next;

  // Access latched when the ack does not arrive in the request cycle
  logic [N-1:0]  r_alu, r_rd3;
  logic          r_we, r_m2r, r_rw;
  logic [3:0]    r_rc;

  // Next MEM/WB contents (all-zero means bubble)
  logic          w_wb_valid, w_wb_rw, w_wb_m2r;
  logic [N-1:0]  w_wb_alu, w_wb_rd;
  logic [3:0]    w_wb_rc;

  assign w_in     = exMemIn;
  assign w_access = inValid & (w_in.mw | w_in.m2r);
  assign w_unused = ^{w_in.ra, w_in.rb, w_in.neg};

  // Branch resolution and forwarding tap come straight from the incoming word
  assign branchTaken  = inValid & w_in.br & w_in.zero;
  assign branchTarget = w_in.alu;
  assign fwdRegWrite  = inValid & w_in.rw;
  assign fwdRc        = w_in.rc;
  assign fwdValue     = w_in.alu;

  // State, wait counter, access latch, error pulse and MEM/WB register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      memErr      <= 1'b0;
      r_alu       <= '0;
      r_rd3       <= '0;
      r_we        <= 1'b0;
      r_m2r       <= 1'b0;
      r_rw        <= 1'b0;
      r_rc        <= '0;
      wbValid     <= 1'b0;
      wbRegWrite  <= 1'b0;
      wbMemToReg  <= 1'b0;
      wbAluResult <= '0;
      wbReadData  <= '0;
      wbRc        <= '0;
    end else begin
      r_state     <= w_next;
      r_cnt       <= w_cnt_next;
      memErr      <= w_err_next;
      wbValid     <= w_wb_valid;
      wbRegWrite  <= w_wb_rw;
      wbMemToReg  <= w_wb_m2r;
      wbAluResult <= w_wb_alu;
      wbReadData  <= w_wb_rd;
      wbRc        <= w_wb_rc;
      if (w_latch) begin
        r_alu <= w_in.alu;
        r_rd3 <= w_in.rd3;
        r_we  <= w_in.mw;
        r_m2r <= w_in.m2r;
        r_rw  <= w_in.rw;
        r_rc  <= w_in.rc;
      end
    end
  end

  // Next state, memory-port drive, stall and MEM/WB next value
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_latch    = 1'b0;
    w_err_next = 1'b0;
    memReq     = 1'b0;
    memWe      = w_in.mw;
    memAddr    = w_in.alu;
    memWData   = w_in.rd3;
    stall      = 1'b0;
    w_wb_valid = 1'b0;
    w_wb_rw    = 1'b0;
    w_wb_m2r   = 1'b0;
    w_wb_alu   = '0;
    w_wb_rd    = '0;
    w_wb_rc    = '0;
    case (r_state)
      S_IDLE: begin
        w_cnt_next = '0;
        if (w_access && !memAck) begin
          memReq  = 1'b1;
          stall   = 1'b1;
          w_latch = 1'b1;
          w_next  = S_WAIT;
        end else if (inValid) begin
          memReq     = w_access;
          w_wb_valid = 1'b1;
          w_wb_rw    = w_in.rw;
          w_wb_m2r   = w_in.m2r;
          w_wb_alu   = w_in.alu;
          w_wb_rc    = w_in.rc;
          w_wb_rd    = (w_in.m2r && !w_in.mw) ? memRData : '0;
        end
      end
      S_WAIT: begin
        memReq     = 1'b1;
        memWe      = r_we;
        memAddr    = r_alu;
        memWData   = r_rd3;
        stall      = 1'b1;
        w_cnt_next = r_cnt + CW'(1);
        if (memAck) begin
          stall      = 1'b0;
          w_next     = S_IDLE;
          w_cnt_next = '0;
          w_wb_valid = 1'b1;
          w_wb_rw    = r_rw;
          w_wb_m2r   = r_m2r;
          w_wb_alu   = r_alu;
          w_wb_rc    = r_rc;
          w_wb_rd    = (r_m2r && !r_we) ? memRData : '0;
        end else if (r_cnt == CW'(TIMEOUT - 1)) begin
          // Last permitted wait cycle: release upstream and drop the access
          stall      = 1'b0;
          w_next     = S_IDLE;
          w_cnt_next = '0;
          w_err_next = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
    if (rst) memReq = 1'b0;
  end

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_mem_stage;

  localparam int N       = 4;
  localparam int TIMEOUT = 15;

  typedef struct packed {
    logic [N-1:0] alu;
    logic         zero;
    logic         neg;
    logic         br;
    logic         mw;
    logic         m2r;
    logic         rw;
    logic [3:0]   ra;
    logic [3:0]   rb;
    logic [3:0]   rc;
    logic [N-1:0] rd3;
  } instr_t;

  typedef struct packed {
    logic         valid;
    logic         rw;
    logic         m2r;
    logic [N-1:0] alu;
    logic [N-1:0] rd;
    logic [3:0]   rc;
  } wb_t;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [2*N+17:0] exMemIn = '0;
  logic            inValid = 1'b0;
  logic            memReq, memWe, stall, memErr, branchTaken;
  logic [N-1:0]    memAddr, memWData, branchTarget, fwdValue;
  logic [N-1:0]    memRData = '0;
  logic            memAck = 1'b0;
  logic            fwdRegWrite, wbValid, wbRegWrite, wbMemToReg;
  logic [3:0]      fwdRc, wbRc;
  logic [N-1:0]    wbAluResult, wbReadData;

  int n_chk  = 0;
  int n_fail = 0;

  mem_stage #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .exMemIn(exMemIn), .inValid(inValid),
    .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWData(memWData),
    .memRData(memRData), .memAck(memAck), .stall(stall), .memErr(memErr),
    .branchTaken(branchTaken), .branchTarget(branchTarget),
    .fwdRegWrite(fwdRegWrite), .fwdRc(fwdRc), .fwdValue(fwdValue),
    .wbValid(wbValid), .wbRegWrite(wbRegWrite), .wbMemToReg(wbMemToReg),
    .wbAluResult(wbAluResult), .wbReadData(wbReadData), .wbRc(wbRc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: an outstanding access (if any) and how many wait cycles it has aged
  logic   m_busy;
  int     m_age;
  instr_t m_p;
  wb_t    m_wb;
  logic   m_err;

  instr_t f;
  logic   e_access, e_req, e_we, e_stall, e_tmo;
  logic [N-1:0] e_addr, e_wd;
  logic   n_busy, n_err;
  int     n_age;
  instr_t n_p;
  wb_t    n_wb;

  function automatic wb_t retire(input instr_t x, input logic [N-1:0] rdata);
    wb_t w;
    w.valid = 1'b1;
    w.rw    = x.rw;
    w.m2r   = x.m2r;
    w.alu   = x.alu;
    w.rc    = x.rc;
    w.rd    = (x.m2r && !x.mw) ? rdata : '0;
    return w;
  endfunction

  always_comb begin
    f        = exMemIn;
    e_access = inValid & (f.mw | f.m2r);
    e_tmo    = m_busy && !memAck && (m_age + 1 >= TIMEOUT);
    if (!m_busy) begin
      e_req = e_access; e_addr = f.alu; e_wd = f.rd3; e_we = f.mw;
      e_stall = e_access && !memAck;
    end else begin
      e_req = 1'b1; e_addr = m_p.alu; e_wd = m_p.rd3; e_we = m_p.mw;
      e_stall = !memAck && !e_tmo;
    end
    if (rst) e_req = 1'b0;
    n_busy = m_busy; n_age = m_age; n_p = m_p; n_wb = '0; n_err = 1'b0;
    if (!m_busy) begin
      if (e_access && memAck)      n_wb = retire(f, memRData);
      else if (e_access) begin     n_busy = 1'b1; n_age = 0; n_p = f; end
      else if (inValid)            n_wb = retire(f, '0);
    end else if (memAck) begin
      n_wb = retire(m_p, memRData); n_busy = 1'b0;
    end else if (e_tmo) begin
      n_err = 1'b1; n_busy = 1'b0;
    end else begin
      n_age = m_age + 1;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0; m_age <= 0; m_p <= '0; m_wb <= '0; m_err <= 1'b0;
    end else begin
      m_busy <= n_busy; m_age <= n_age; m_p <= n_p; m_wb <= n_wb; m_err <= n_err;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    chk("memReq", 32'(memReq), 32'(e_req));
    if (e_req) begin
      chk("memWe", 32'(memWe), 32'(e_we));
      chk("memAddr", 32'(memAddr), 32'(e_addr));
      chk("memWData", 32'(memWData), 32'(e_wd));
    end
    chk("stall", 32'(stall), 32'(e_stall));
    chk("memErr", 32'(memErr), 32'(m_err));
    chk("branchTaken", 32'(branchTaken), 32'(inValid & f.br & f.zero));
    chk("branchTarget", 32'(branchTarget), 32'(f.alu));
    chk("fwdRegWrite", 32'(fwdRegWrite), 32'(inValid & f.rw));
    chk("fwdRc", 32'(fwdRc), 32'(f.rc));
    chk("fwdValue", 32'(fwdValue), 32'(f.alu));
    chk("wbValid", 32'(wbValid), 32'(m_wb.valid));
    chk("wbRegWrite", 32'(wbRegWrite), 32'(m_wb.rw));
    chk("wbMemToReg", 32'(wbMemToReg), 32'(m_wb.m2r));
    chk("wbAluResult", 32'(wbAluResult), 32'(m_wb.alu));
    chk("wbReadData", 32'(wbReadData), 32'(m_wb.rd));
    chk("wbRc", 32'(wbRc), 32'(m_wb.rc));
  end

  task automatic set_in(input logic v, input logic [N-1:0] alu, input logic zero,
                        input logic br, input logic mw, input logic m2r, input logic rw,
                        input logic [3:0] rc, input logic [N-1:0] rd3);
    instr_t x;
    x = '0;
    x.alu = alu; x.zero = zero; x.br = br; x.mw = mw; x.m2r = m2r; x.rw = rw;
    x.rc = rc; x.rd3 = rd3; x.ra = 4'(rc + 1); x.rb = 4'(rc + 2);
    exMemIn = x;
    inValid = v;
  endtask

  task automatic bubble();
    set_in(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int   cnt;
  logic hold;
  int   ack_pct;

  initial begin
    #2 rst = 1'b1;
    #1;
    chk("rst_wbValid", 32'(wbValid), 32'd0);
    chk("rst_memReq", 32'(memReq), 32'd0);
    chk("rst_memErr", 32'(memErr), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // ALU op
    set_in(1'b1, 4'h9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 4'h0);
    @(negedge clk);
    chk("alu_noReq", 32'(memReq), 32'd0);
    step(); bubble();
    @(negedge clk);
    chk("alu_wbValid", 32'(wbValid), 32'd1);
    chk("alu_wbAlu", 32'(wbAluResult), 32'h9);
    chk("alu_wbRc", 32'(wbRc), 32'd3);
    chk("alu_wbRd", 32'(wbReadData), 32'd0);

    // Zero-wait load
    step();
    set_in(1'b1, 4'h5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd6, 4'h0);
    memAck = 1'b1; memRData = 4'hA;
    @(negedge clk);
    chk("ld_req", 32'(memReq), 32'd1);
    chk("ld_addr", 32'(memAddr), 32'h5);
    chk("ld_we", 32'(memWe), 32'd0);
    chk("ld_stall", 32'(stall), 32'd0);
    step(); bubble(); memAck = 1'b0;
    @(negedge clk);
    chk("ld_wbValid", 32'(wbValid), 32'd1);
    chk("ld_wbRd", 32'(wbReadData), 32'hA);
    chk("ld_wbM2r", 32'(wbMemToReg), 32'd1);

    // Store acked three cycles after the request cycle
    step();
    set_in(1'b1, 4'h2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 4'h7);
    cnt = 0;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) memAck = 1'b1;
      @(negedge clk);
      chk("st_req", 32'(memReq), 32'd1);
      chk("st_we", 32'(memWe), 32'd1);
      chk("st_addr", 32'(memAddr), 32'h2);
      chk("st_wdata", 32'(memWData), 32'h7);
      if (c > 0) chk("st_bubble", 32'(wbValid), 32'd0);
      if (stall) cnt++;
      step();
    end
    bubble(); memAck = 1'b0;
    @(negedge clk);
    chk("st_stallCycles", 32'(cnt), 32'd3);
    chk("st_wbValid", 32'(wbValid), 32'd1);
    chk("st_wbRw", 32'(wbRegWrite), 32'd0);
    chk("st_wbRd", 32'(wbReadData), 32'd0);

    // Load that never gets an ack
    step();
    set_in(1'b1, 4'hB, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd4, 4'h0);
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!stall) break;
      chk("to_noErrYet", 32'(memErr), 32'd0);
      cnt++;
      step();
    end
    chk("to_stallCycles", 32'(cnt), 32'(TIMEOUT));
    step(); bubble();
    @(negedge clk);
    chk("to_err", 32'(memErr), 32'd1);
    chk("to_req", 32'(memReq), 32'd0);
    chk("to_wbValid", 32'(wbValid), 32'd0);
    chk("to_stall", 32'(stall), 32'd0);
    step();
    @(negedge clk);
    chk("to_errPulse", 32'(memErr), 32'd0);

    // Branch resolution and forwarding tap
    step();
    set_in(1'b1, 4'hC, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd5, 4'h0);
    #1;
    chk("br_taken", 32'(branchTaken), 32'd1);
    chk("br_target", 32'(branchTarget), 32'hC);
    chk("fwd_rw", 32'(fwdRegWrite), 32'd1);
    chk("fwd_rc", 32'(fwdRc), 32'd5);
    chk("fwd_val", 32'(fwdValue), 32'hC);
    set_in(1'b1, 4'hC, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd5, 4'h0);
    #1;
    chk("br_notZero", 32'(branchTaken), 32'd0);
    set_in(1'b0, 4'hC, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd5, 4'h0);
    #1;
    chk("br_invalid", 32'(branchTaken), 32'd0);
    chk("fwd_invalid", 32'(fwdRegWrite), 32'd0);

    // Reset in the middle of a wait
    step();
    set_in(1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd2, 4'h0);
    step();
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("rw_req", 32'(memReq), 32'd0);
    chk("rw_wbValid", 32'(wbValid), 32'd0);
    chk("rw_err", 32'(memErr), 32'd0);
    bubble();
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rw_noReq", 32'(memReq), 32'd0);

    // Randomized traffic: mixed, sparse and immediate acks
    for (int ph = 0; ph < 3; ph++) begin
      ack_pct = (ph == 0) ? 50 : (ph == 1) ? 5 : 100;
      for (int c = 0; c < 1000; c++) begin
        @(negedge clk);
        hold = e_stall;
        step();
        if (!hold || $urandom_range(0, 7) == 0) begin
          exMemIn = (2*N+18)'({$urandom, $urandom});
          inValid = ($urandom_range(0, 3) != 0);
        end
        memAck   = ($urandom_range(1, 100) <= ack_pct);
        memRData = N'($urandom);
      end
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
